// File: rtl/gold_pkg.sv
// Shared constants and types for the gold-code beacon synchronizer.
package gold_pkg;
  localparam int GOLD_LEN = 63;
  localparam logic [GOLD_LEN-1:0] GOLD_DEFAULT =
    63'b000001000011000101001111010001110010010110111011001101010111111;

  typedef enum logic {SEARCH = 1'b0, LOCK = 1'b1} state_e;
  typedef logic [5:0] cnt_t;
endpackage

// File: rtl/gold_popcount63.sv
// Combinational popcount of a 63-bit vector; the caller registers the result.
module gold_popcount63 import gold_pkg::*; (
  input  logic [GOLD_LEN-1:0] vec_i,
  output cnt_t                cnt_o
);
  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < GOLD_LEN; i++) cnt_o = cnt_o + cnt_t'(vec_i[i]);
  end
endmodule

// File: rtl/gold_sync.sv
// Gold-code beacon synchronizer: sliding-correlation acquisition, then chip tracking.
// Optional GOLD_SYNC_INVERT_EN also acquires and tracks the inverted code.
module gold_sync import gold_pkg::*; #(
  parameter int unsigned          CLK_DIV    = 8,
  parameter logic [GOLD_LEN-1:0]  GOLD       = GOLD_DEFAULT,
  parameter int unsigned          ACQ_THRESH = 58,
  parameter int unsigned          LOSS_ERR   = 8
)(
  input  logic       clk,
  input  logic       reset,
  input  logic       in_bit,
  output logic       chip_strobe,
  output logic       locked,
  output logic       frame_start,
  output logic [5:0] corr_peak,
  output logic [5:0] err_count,
  output logic       polarity
);
  localparam int   DW     = $clog2(CLK_DIV);
  localparam cnt_t ACQ_T  = cnt_t'(ACQ_THRESH);
  localparam cnt_t LOSS_T = cnt_t'(LOSS_ERR);
  localparam cnt_t LEN_C  = cnt_t'(GOLD_LEN);
  localparam cnt_t LAST_C = cnt_t'(GOLD_LEN - 1);
`ifdef GOLD_SYNC_INVERT_EN
  localparam cnt_t INV_T  = cnt_t'(GOLD_LEN - ACQ_THRESH);
`endif

  logic                s_q;
  logic [DW-1:0]       div_q, div_d;
  logic [GOLD_LEN-1:0] sr_q, sr_d;
  state_e              state_q, state_d;
  cnt_t                match_q, match_d, pop;
  logic [1:0]          vld_pipe_q, vld_pipe_d;
  cnt_t                search_cnt_q, search_cnt_d;
  cnt_t                chip_idx_q, chip_idx_d;
  cnt_t                err_acc_q, err_acc_d, err_tot;
  logic                locked_q, locked_d, frame_start_q, frame_start_d;
  cnt_t                corr_peak_q, corr_peak_d, err_count_q, err_count_d;
  logic                polarity_q, polarity_d;
  logic                stb, acq_true, acq_inv, mism;

  gold_popcount63 u_pop (.vec_i(~(sr_q ^ GOLD)), .cnt_o(pop));

  assign stb         = (div_q == DW'(CLK_DIV - 1));
  assign acq_true    = (match_q >= ACQ_T);
`ifdef GOLD_SYNC_INVERT_EN
  assign acq_inv     = (match_q <= INV_T);
`else
  assign acq_inv     = 1'b0;
`endif
  // sr[62] is the chip shifted in by the strobe one cycle earlier.
  assign mism        = sr_q[GOLD_LEN-1] ^ GOLD[chip_idx_q] ^ polarity_q;
  assign err_tot     = err_acc_q + cnt_t'(mism);

  always_comb begin
    div_d         = stb ? '0 : div_q + 1'b1;
    sr_d          = stb ? {s_q, sr_q[GOLD_LEN-1:1]} : sr_q;
    match_d       = vld_pipe_q[0] ? pop : match_q;
    vld_pipe_d    = {vld_pipe_q[0] && (state_q == SEARCH), stb};
    state_d       = state_q;
    search_cnt_d  = search_cnt_q;
    chip_idx_d    = chip_idx_q;
    err_acc_d     = err_acc_q;
    locked_d      = locked_q;
    frame_start_d = 1'b0;
    corr_peak_d   = corr_peak_q;
    err_count_d   = err_count_q;
    polarity_d    = polarity_q;
    unique case (state_q)
      SEARCH: if (vld_pipe_q[1]) begin
        if (acq_true || acq_inv) begin
          state_d      = LOCK;
          locked_d     = 1'b1;
          corr_peak_d  = acq_inv ? LEN_C - match_q : match_q;
          polarity_d   = acq_inv;
          chip_idx_d   = '0;
          err_acc_d    = '0;
          search_cnt_d = '0;
        end else if (search_cnt_q == LAST_C) begin
          // Phase slip: stretch this chip by one clock to move the sample point.
          search_cnt_d = '0;
          div_d        = div_q;
        end else begin
          search_cnt_d = search_cnt_q + 1'b1;
        end
      end
      LOCK: if (vld_pipe_q[0]) begin
        if (chip_idx_q == LAST_C) begin
          frame_start_d = 1'b1;
          err_count_d   = err_tot;
          err_acc_d     = '0;
          chip_idx_d    = '0;
          if (err_tot > LOSS_T) begin
            state_d      = SEARCH;
            locked_d     = 1'b0;
            sr_d         = '0;
            search_cnt_d = '0;
          end
        end else begin
          err_acc_d  = err_tot;
          chip_idx_d = chip_idx_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_q           <= 1'b0;
      div_q         <= '0;
      sr_q          <= '0;
      state_q       <= SEARCH;
      match_q       <= '0;
      vld_pipe_q    <= '0;
      search_cnt_q  <= '0;
      chip_idx_q    <= '0;
      err_acc_q     <= '0;
      locked_q      <= 1'b0;
      frame_start_q <= 1'b0;
      corr_peak_q   <= '0;
      err_count_q   <= '0;
      polarity_q    <= 1'b0;
    end else begin
      s_q           <= in_bit;
      div_q         <= div_d;
      sr_q          <= sr_d;
      state_q       <= state_d;
      match_q       <= match_d;
      vld_pipe_q    <= vld_pipe_d;
      search_cnt_q  <= search_cnt_d;
      chip_idx_q    <= chip_idx_d;
      err_acc_q     <= err_acc_d;
      locked_q      <= locked_d;
      frame_start_q <= frame_start_d;
      corr_peak_q   <= corr_peak_d;
      err_count_q   <= err_count_d;
      polarity_q    <= polarity_d;
    end
  end

  assign chip_strobe = vld_pipe_q[0];
  assign locked      = locked_q;
  assign frame_start = frame_start_q;
  assign corr_peak   = corr_peak_q;
  assign err_count   = err_count_q;
  assign polarity    = polarity_q;
endmodule

// File: tb/tb_gold_sync.sv
// Directed bench for gold_sync: cycle t counts clocks since reset release,
// outputs are sampled 1 time unit after each rising edge.
module tb_gold_sync;
  logic       clk = 1'b0, reset = 1'b1, in_bit = 1'b0;
  logic       chip_strobe, locked, frame_start, polarity;
  logic [5:0] corr_peak, err_count;

  gold_sync dut (
    .clk(clk), .reset(reset), .in_bit(in_bit),
    .chip_strobe(chip_strobe), .locked(locked), .frame_start(frame_start),
    .corr_peak(corr_peak), .err_count(err_count), .polarity(polarity)
  );

  always #5 clk = ~clk;

  logic [62:0] gold_v = 63'b000001000011000101001111010001110010010110111011001101010111111;
  logic [62:0] emask;
  logic        inv;
  int          off, zero_from, t;
  int          n_chk = 0, n_err = 0;
  logic        relock;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d (cycle %0d)", tag, obs, exp, t);
    end
  endtask

  // Source: chip k lasts 8 clocks, delayed by off clocks, optional flips/inversion.
  function automatic logic src(input int n);
    int idx;
    if (n >= zero_from) return 1'b0;
    idx = ((n + 8 * 63 * 4 - off) / 8) % 63;
    return gold_v[idx] ^ emask[idx] ^ inv;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    t++;
    in_bit = src(t);
  endtask

  task automatic run_to(input int c);
    while (t < c) tick();
  endtask

  task automatic rst_start(input int cyc, input int o, input logic iv, input logic [62:0] em);
    reset  = 1'b1;
    in_bit = 1'b0;
    repeat (cyc) @(posedge clk);
    #1;
    chk("rst_outs", int'({chip_strobe, locked, frame_start, corr_peak, err_count, polarity}), 0);
    off = o; inv = iv; emask = em; zero_from = 1 << 30;
    reset  = 1'b0;
    t      = 0;
    in_bit = src(0);
  endtask

  initial begin
    off = 0; inv = 1'b0; emask = '0; zero_from = 1 << 30; t = 0; relock = 1'b0;

    // Reset, first strobe, clean aligned acquisition on the slip boundary
    rst_start(5, 0, 1'b0, '0);
    run_to(7);    chk("stb_c7", chip_strobe, 0);
    run_to(8);    chk("stb_c8", chip_strobe, 1);
    run_to(9);    chk("stb_c9", chip_strobe, 0);
    run_to(505);  chk("lock_c505", locked, 0);
    run_to(506);  chk("lock_c506", locked, 1);
    chk("peak_clean", corr_peak, 63);
    chk("pol_clean", polarity, 0);
    run_to(512);  chk("stb_noslip", chip_strobe, 1);
    run_to(1008); chk("fs_c1008", frame_start, 0);
    run_to(1009); chk("fs_c1009", frame_start, 1);
    chk("err_clean", err_count, 0);
    run_to(1010); chk("fs_c1010", frame_start, 0);

    // Lock loss: all-zero input for one whole period
    zero_from = 1010;
    run_to(1512); chk("lock_pre_loss", locked, 1);
    run_to(1513); chk("fs_loss", frame_start, 1);
    chk("err_loss", err_count, 32);
    chk("lock_loss", locked, 0);
    while (t < 2600) begin
      tick();
      relock |= locked;
    end
    chk("no_relock", relock, 0);
    chk("peak_hold", corr_peak, 63);
    chk("err_hold", err_count, 32);

    // Offset 3 clocks, 5 flipped chips per period: acquire at threshold, hold lock
    emask = '0;
    emask[3] = 1'b1; emask[17] = 1'b1; emask[30] = 1'b1; emask[45] = 1'b1; emask[60] = 1'b1;
    rst_start(2, 3, 1'b0, emask);
    run_to(506);  chk("lock_err", locked, 1);
    chk("peak_thresh", corr_peak, 58);
    for (int k = 0; k < 3; k++) begin
      run_to(1008 + 504 * k); chk("lock_hold", locked, 1);
      run_to(1009 + 504 * k); chk("fs_err", frame_start, 1);
      chk("err_five", err_count, 5);
    end

    // Reset for one clock mid-lock, then normal re-acquisition
    run_to(2067); chk("lock_before_rst", locked, 1);
    rst_start(1, 0, 1'b0, '0);
    run_to(505);  chk("relock_c505", locked, 0);
    run_to(506);  chk("relock_c506", locked, 1);
    chk("relock_peak", corr_peak, 63);

    // Inverted code
    rst_start(1, 0, 1'b1, '0);
`ifdef GOLD_SYNC_INVERT_EN
    run_to(506);  chk("inv_lock", locked, 1);
    chk("inv_pol", polarity, 1);
    chk("inv_peak", corr_peak, 63);
    run_to(1009); chk("inv_fs", frame_start, 1);
    chk("inv_err", err_count, 0);
    chk("inv_lock_hold", locked, 1);
`else
    run_to(506);  chk("inv_nolock", locked, 0);
    run_to(512);  chk("slip1_c512", chip_strobe, 0);
    run_to(513);  chk("slip1_c513", chip_strobe, 1);
    run_to(1017); chk("slip2_c1017", chip_strobe, 0);
    run_to(1018); chk("slip2_c1018", chip_strobe, 1);
    run_to(1100); chk("inv_nolock_end", locked, 0);
    chk("inv_pol0", polarity, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
